// File: rtl/sr_cmd_sequencer_if.sv
// sr_cmd_sequencer_if
//   Request handshake into the SR command sequencer.
//   req_valid  : request present (master -> slave)
//   req_op     : 00 nop, 01 clear, 10 set, 11 toggle/illegal (master -> slave)
//   req_ready  : slave can accept; transfer = req_valid & req_ready at posedge
//   Modports: master (requester side), slave (sequencer side).
interface sr_cmd_sequencer_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;

  modport master (output req_valid, output req_op, input req_ready);
  modport slave  (input req_valid, input req_op, output req_ready);
endinterface

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Upstream command stage for the srff block. Set/clear requests arrive on a
//   valid/ready handshake, are buffered in a DEPTH-entry FIFO and are issued to
//   the flop as one-cycle, mutually exclusive S/R pulses separated by MIN_GAP
//   idle cycles. A shadow copy of the flop's Q is kept for status and for
//   resolving toggle commands.
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous, active-high reset
//   req          sr_cmd_sequencer_if.slave (req_valid, req_op, req_ready)
//   s_out        set pulse to the flop's S
//   r_out        reset pulse to the flop's R
//   q_shadow     predicted flop Q
//   busy         FIFO non-empty or FSM not idle
//   err_illegal  one-cycle pulse when an illegal op is accepted
//   illegal_cnt  saturating count of illegal ops
// Configuration
//   SR_TOGGLE_CMD_EN defined  : op 11 is a toggle, queued and resolved at pop
//                               time against the predicted Q.
//   SR_TOGGLE_CMD_EN undefined: op 11 is accepted, dropped and counted as
//                               illegal.
module sr_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  sr_cmd_sequencer_if.slave req,
  output logic              s_out,
  output logic              r_out,
  output logic              q_shadow,
  output logic              busy,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  logic [1:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  state_t           state_reg;
  logic [3:0]       gap_cnt_reg;
  logic             s_reg, r_reg, q_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic       full, empty, accept, push, pop, illegal_acc;
  logic [1:0] head;
  logic       q_now, head_is_set;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot for a push.
  assign req.req_ready = !full;
  assign accept        = req.req_valid && !full;

`ifdef SR_TOGGLE_CMD_EN
  assign push        = accept && (req.req_op != 2'b00);
  assign illegal_acc = 1'b0;
`else
  assign push        = accept && ((req.req_op == 2'b01) || (req.req_op == 2'b10));
  assign illegal_acc = accept && (req.req_op == 2'b11);
`endif

  // Pop from IDLE, or back-to-back from PULSE when no gap is configured.
  assign pop = !empty && ((state_reg == IDLE) ||
                          ((state_reg == PULSE) && (MIN_GAP == 0)));

  assign head = fifo_mem[rd_ptr_reg];

  // Q as it will be after the current edge: a pulse in flight is already
  // committed, so a toggle popped back-to-back sees the post-pulse value.
  assign q_now       = s_reg ? 1'b1 : (r_reg ? 1'b0 : q_reg);
  assign head_is_set = (head == 2'b10) || ((head == 2'b11) && !q_now);

  // Storage has no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= req.req_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      s_reg       <= 1'b0;
      r_reg       <= 1'b0;
      q_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            s_reg     <= head_is_set;
            r_reg     <= !head_is_set;
            state_reg <= PULSE;
          end
        end
        PULSE: begin
          q_reg <= q_now;
          if (pop) begin
            s_reg <= head_is_set;
            r_reg <= !head_is_set;
          end else begin
            s_reg <= 1'b0;
            r_reg <= 1'b0;
            if (MIN_GAP > 0) begin
              state_reg   <= GAP;
              gap_cnt_reg <= 4'(MIN_GAP - 1);
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      err_reg <= illegal_acc;
      if (illegal_acc && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign s_out       = s_reg;
  assign r_out       = r_reg;
  assign q_shadow    = q_reg;
  assign busy        = !empty || (state_reg != IDLE);
  assign err_illegal = err_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb_sr_cmd_sequencer
//   Directed bench for sr_cmd_sequencer (DEPTH=4, MIN_GAP=1, CNT_W=8).
//   A per-cycle vector table covers single set/clear, nop and op 11, followed
//   by hand-written sequences for back-pressure, illegal-count saturation (or
//   toggle chains when SR_TOGGLE_CMD_EN is defined) and reset mid-pulse.
module tb_sr_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_out, r_out, q_shadow, busy, err_illegal;
  logic [7:0] illegal_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  sr_cmd_sequencer_if rif ();

  sr_cmd_sequencer #(.DEPTH(4), .MIN_GAP(1), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (rif),
    .s_out       (s_out),
    .r_out       (r_out),
    .q_shadow    (q_shadow),
    .busy        (busy),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic       ready;
    logic       s;
    logic       r;
    logic       q;
    logic       busy;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [6];
    int         ops_done, npulse, extra, exp_cnt;
    int         pcyc [6];
    logic       pkind [6];
    logic       fire, saw_full, sr_both, any_pulse;

    // ---------------- vector table (inputs before edge, outputs after) ----
    vecs[0]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
`ifdef SR_TOGGLE_CMD_EN
    vecs[8]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
`else
    vecs[8]  = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
`endif

    // ---------------- reset held 3 cycles with a set request present ------
    reset         = 1'b1;
    rif.req_valid = 1'b1;
    rif.req_op    = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_s",    s_out,       0);
      check("rst_r",    r_out,       0);
      check("rst_q",    q_shadow,    0);
      check("rst_busy", busy,        0);
      check("rst_err",  err_illegal, 0);
      check("rst_cnt",  illegal_cnt, 0);
      $display("reset cycle %0d: s=%0b r=%0b q=%0b busy=%0b", i, s_out, r_out, q_shadow, busy);
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    reset         = 1'b0;
    check("rst_ready_after", rif.req_ready, 1);
    @(posedge clk); #1;
    check("rst_busy_after", busy, 0);
    check("rst_no_pulse", s_out | r_out, 0);

    // ---------------- table-driven vectors --------------------------------
    for (int i = 0; i < 12; i++) begin
      rif.req_valid = vecs[i].v;
      rif.req_op    = vecs[i].op;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready", i), rif.req_ready, vecs[i].ready);
      check($sformatf("vec%0d_s", i),     s_out,         vecs[i].s);
      check($sformatf("vec%0d_r", i),     r_out,         vecs[i].r);
      check($sformatf("vec%0d_q", i),     q_shadow,      vecs[i].q);
      check($sformatf("vec%0d_busy", i),  busy,          vecs[i].busy);
      check($sformatf("vec%0d_err", i),   err_illegal,   vecs[i].err);
      check($sformatf("vec%0d_cnt", i),   illegal_cnt,   vecs[i].cnt);
      $display("vec %0d: v=%0b op=%0d -> rdy=%0b s=%0b r=%0b q=%0b busy=%0b err=%0b cnt=%0d",
               i, vecs[i].v, vecs[i].op, rif.req_ready, s_out, r_out, q_shadow, busy,
               err_illegal, illegal_cnt);
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;

    // ---------------- back-pressure: 6 back-to-back requests --------------
    seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10;
    seq[3] = 2'b01; seq[4] = 2'b10; seq[5] = 2'b01;
    ops_done = 0; npulse = 0; extra = 0;
    saw_full = 1'b0; sr_both = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (ops_done >= 6 && npulse >= 6 && !busy) break;
      rif.req_valid = (ops_done < 6);
      rif.req_op    = (ops_done < 6) ? seq[ops_done] : 2'b00;
      fire = rif.req_valid && rif.req_ready;
      @(posedge clk);
      if (fire) ops_done++;
      #1;
      if (!rif.req_ready) saw_full = 1'b1;
      if (s_out && r_out) sr_both = 1'b1;
      if (s_out || r_out) begin
        if (npulse < 6) begin
          pkind[npulse] = s_out;
          pcyc[npulse]  = cyc;
          npulse++;
        end else begin
          extra++;
        end
      end
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    check("bp_accepted",  ops_done, 6);
    check("bp_pulses",    npulse,   6);
    check("bp_extra",     extra,    0);
    check("bp_saw_full",  saw_full, 1);
    check("bp_exclusive", sr_both,  0);
    for (int i = 0; i < 6 && i < npulse; i++) begin
      check($sformatf("bp_kind%0d", i), pkind[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check($sformatf("bp_gap%0d", i), pcyc[i] - pcyc[i-1], 3);
      $display("bp pulse %0d: %s at cycle %0d", i, pkind[i] ? "S" : "R", pcyc[i]);
    end
    check("bp_final_q", q_shadow, 0);

`ifdef SR_TOGGLE_CMD_EN
    // ---------------- toggle chain from q_shadow=0 ------------------------
    check("tg_start_q", q_shadow, 0);
    for (int i = 0; i < 3; i++) begin
      rif.req_valid = 1'b1;
      rif.req_op    = 2'b11;
      @(posedge clk); #1;
      $display("toggle %0d queued: s=%0b r=%0b q=%0b", i, s_out, r_out, q_shadow);
      if (s_out || r_out) begin
        if (npulse < 6) begin pkind[0] = s_out; end
      end
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    // Collect the three pulses; the first can fire during queueing (cycle k+1).
    npulse = 0; extra = 0; sr_both = 1'b0;
    // The first pulse fires at the second queueing edge; it was captured
    // above only if visible, so re-derive the order from a fresh trace.
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!busy) break;
      @(posedge clk); #1;
      if (s_out && r_out) sr_both = 1'b1;
      if (s_out || r_out) begin
        if (npulse < 2) begin pkind[1 + npulse] = s_out; npulse++; end
        else extra++;
      end
    end
    check("tg_pulses_after_queue", npulse, 2);
    check("tg_extra",  extra, 0);
    check("tg_excl",   sr_both, 0);
    check("tg_p0_set", pkind[0], 1);
    check("tg_p1_rst", pkind[1], 0);
    check("tg_p2_set", pkind[2], 1);
    check("tg_final_q", q_shadow, 1);
    check("tg_err",    err_illegal, 0);
    check("tg_cnt",    illegal_cnt, 0);
`else
    // ---------------- illegal op repeated 300 times: saturation -----------
    exp_cnt   = 1;
    any_pulse = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rif.req_valid = 1'b1;
      rif.req_op    = 2'b11;
      @(posedge clk); #1;
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      if (s_out || r_out) any_pulse = 1'b1;
      check($sformatf("ill%0d_cnt", i), illegal_cnt, exp_cnt);
      check($sformatf("ill%0d_err", i), err_illegal, 1);
      $display("illegal %0d: err=%0b cnt=%0d", i, err_illegal, illegal_cnt);
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    @(posedge clk); #1;
    check("ill_err_drop", err_illegal, 0);
    check("ill_cnt_sat",  illegal_cnt, 255);
    check("ill_no_pulse", any_pulse, 0);
    check("ill_busy",     busy, 0);
`endif

    // ---------------- reset during PULSE with 3 entries queued ------------
    for (int i = 0; i < 5; i++) begin
      rif.req_valid = 1'b1;
      rif.req_op    = 2'b10;
      @(posedge clk); #1;
      $display("mid-reset push %0d: rdy=%0b s=%0b busy=%0b", i, rif.req_ready, s_out, busy);
    end
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    check("mr_pre_s",    s_out, 1);
    check("mr_pre_busy", busy,  1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mr_s",     s_out,    0);
    check("mr_r",     r_out,    0);
    check("mr_q",     q_shadow, 0);
    check("mr_busy",  busy,     0);
    check("mr_ready", rif.req_ready, 1);
    any_pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (s_out || r_out || busy) any_pulse = 1'b1;
    end
    check("mr_no_further_pulse", any_pulse, 0);
    check("mr_q_after", q_shadow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
